priority_decoder_3line: RTL and testbench
=========================================

// Module: priority_decoder_3line
// PURPOSE
//   Inverse of the 3-line priority encoder: accepts an encoded index and
//     valid over a valid/ready handshake, and returns a registered one-hot line vector.
//   2-entry FIFO decouples producer and consumer; out-of-range indices are
//     dropped and flagged.
//   Sits downstream of the encoder; drives per-line grant/enable logic.
// PARAMETERS
//   N      3  number of decoded lines (one-hot width)
//   IDX_W  2  encoded index width; legal indices 0..N-1
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      encoded index valid (encoder 'valid')
//   in_idx      in   IDX_W  encoded index (encoder 'out')
//   in_ready    out  1      buffer can accept
//   out_valid   out  1      head entry available
//   out_onehot  out  N      one-hot line vector of head entry
//   out_ready   in   1      consumer takes head entry
//   err_clr     in   1      clears err_oor
//   err_oor     out  1      sticky: out-of-range index received
//   level       out  2      current occupancy, 0..2
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFO flushed, level=0, out_valid=0,
//     out_onehot=0, err_oor=0; in_ready=1 while level<2 (also during reset).
//   - Push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (level<2), purely from registered state; no combinational
//     in_ready<-out_ready path. When full, a same-cycle pop does not admit a push.
//   - Push with in_idx<N: stores (1<<in_idx) as N-bit one-hot.
//   - Push with in_idx>=N: handshake completes, entry NOT stored, level unchanged,
//     err_oor set next cycle.
//   - Latency: legal push into empty FIFO -> out_valid=1 the next cycle.
//   - out_onehot/out_valid change only on the clock edge; both are held stable
//     while out_valid=1 and out_ready=0.
//   - out_onehot=0 whenever out_valid=0.
//   - Simultaneous legal push and pop at level=1: level stays 1, new entry becomes head.
//   - level updates as +1 (push only), -1 (pop only), unchanged (both or neither).
//   - Pointers are 1-bit and wrap 1->0.
//   - err_oor: set has priority over err_clr in the same cycle; otherwise
//     err_clr clears it.
//   - Ordering is strict FIFO; entries are never dropped once stored.
//   - Reset mid-operation discards all entries immediately (async).
//   - in_valid=0 with any in_idx: no effect (matches encoder idle 00/0).
// CONFIGURATION
//   LINE_HIST_EN defined:
//     - Adds output hist_mask [N] and input hist_clr [1].
//     - hist_mask ORs in out_onehot on every pop.
//     - hist_clr zeroes hist_mask; a pop in the same cycle still ORs in its bit.
//     - Reset value of hist_mask is 0.
//   LINE_HIST_EN undefined: ports and logic absent; all other behaviour identical.
// TESTING
//   T1 reset: assert rst mid-stream with level=2 -> level=0, out_valid=0,
//      out_onehot=000, in_ready=1 immediately.
//   T2 decode: push idx 0,1,2 with out_ready=1 -> out_onehot 001,010,100 each
//      one cycle after its push, in order.
//   T3 backpressure: out_ready=0, push idx 2,0,1 -> level=2 after 2 pushes,
//      in_ready=0, third held; release -> 100,001,010 in order.
//   T4 illegal: push idx 3 -> no out_valid, level unchanged, err_oor=1;
//      err_clr -> 0; idx 3 plus err_clr together -> err_oor stays 1.
//   T5 full + pop: level=2, out_ready=1, in_valid=1 -> no push that cycle,
//      level=1; push accepted next cycle.
//   T6 LINE_HIST_EN: pop 001 then 100 -> hist_mask=101; hist_clr with pop 010
//      -> hist_mask=010.

Source files
------------

// File: rtl/priority_decoder_3line.sv
// Decodes an encoded line index into a one-hot vector through a 2-entry FIFO.
// Optional LINE_HIST_EN adds a sticky per-line history of popped entries.
module priority_decoder_3line #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_onehot,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic             err_oor,
`ifdef LINE_HIST_EN
    input  logic             hist_clr,
    output logic [N-1:0]     hist_mask,
`endif
    output logic [1:0]       level
);

    logic [N-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         push;
    logic         push_ok;
    logic         pop;
    logic         legal;
    logic [N-1:0] dec;

    assign in_ready   = (level < 2'd2);
    assign out_valid  = (level != 2'd0);
    assign out_onehot = out_valid ? mem[rptr] : '0;

    assign push    = in_valid & in_ready;
    assign legal   = ({1'b0, in_idx} < (IDX_W+1)'(N));
    assign push_ok = push & legal;
    assign pop     = out_valid & out_ready;

    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_idx == IDX_W'(i))
                dec[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++)
                mem[i] <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            level   <= 2'd0;
            err_oor <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= dec;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push_ok, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
            // Setting wins over clearing when both happen in one cycle.
            if (push && !legal)
                err_oor <= 1'b1;
            else if (err_clr)
                err_oor <= 1'b0;
        end
    end

`ifdef LINE_HIST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist_mask <= '0;
        else
            hist_mask <= (hist_clr ? '0 : hist_mask) | (pop ? out_onehot : '0);
    end
`endif

endmodule

// File: tb/tb_priority_decoder_3line.sv
// Directed self-checking bench for priority_decoder_3line.
// Hist checks are compiled in only when LINE_HIST_EN is defined.
module tb_priority_decoder_3line;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_idx;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_onehot;
    logic       out_ready;
    logic       err_clr;
    logic       err_oor;
    logic [1:0] level;
`ifdef LINE_HIST_EN
    logic       hist_clr;
    logic [2:0] hist_mask;
`endif

    int vectors;
    int miscompares;

    priority_decoder_3line #(.N(3), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .err_oor    (err_oor),
`ifdef LINE_HIST_EN
        .hist_clr   (hist_clr),
        .hist_mask  (hist_mask),
`endif
        .level      (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] lvl, input logic [2:0] oh);
        check({tag, "_level"}, 32'(level), 32'(lvl));
        check({tag, "_valid"}, 32'(out_valid), 32'(lvl != 2'd0));
        check({tag, "_onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, "_ready"}, 32'(in_ready), 32'(lvl != 2'd2));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_idx    = 2'd0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
`ifdef LINE_HIST_EN
        hist_clr  = 1'b0;
`endif
        #2;
        chk_state("rst0", 2'd0, 3'b000);
        check("rst0_err", 32'(err_oor), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_state("idle", 2'd0, 3'b000);

        // T2: decode each legal index with the consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_idx    = 2'd0;
        tick();
        chk_state("t2_i0", 2'd1, 3'b001);
        in_idx = 2'd1;
        tick();
        chk_state("t2_i1", 2'd1, 3'b010);
        in_idx = 2'd2;
        tick();
        chk_state("t2_i2", 2'd1, 3'b100);
        in_valid = 1'b0;
        tick();
        chk_state("t2_drain", 2'd0, 3'b000);

        // T3/T5: backpressure, fill, then pop while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 2'd2;
        tick();
        chk_state("t3_p1", 2'd1, 3'b100);
        in_idx = 2'd0;
        tick();
        chk_state("t3_p2", 2'd2, 3'b100);
        in_idx = 2'd1;
        tick();
        chk_state("t3_hold", 2'd2, 3'b100);
        out_ready = 1'b1;
        tick();
        chk_state("t5_fullpop", 2'd1, 3'b001);
        tick();
        chk_state("t5_pushnext", 2'd1, 3'b010);
        in_valid = 1'b0;
        tick();
        chk_state("t3_drain", 2'd0, 3'b000);

        // T4: out-of-range index handling and sticky error
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 2'd3;
        tick();
        chk_state("t4_oor", 2'd0, 3'b000);
        check("t4_err_set", 32'(err_oor), 32'd1);
        in_valid = 1'b0;
        err_clr  = 1'b1;
        tick();
        check("t4_err_clr", 32'(err_oor), 32'd0);
        in_valid = 1'b1;
        tick();
        check("t4_set_beats_clr", 32'(err_oor), 32'd1);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        in_idx   = 2'd2;
        tick();
        check("t4_sticky", 32'(err_oor), 32'd1);
        chk_state("t4_idle_idx", 2'd0, 3'b000);
        in_valid = 1'b1;
        in_idx   = 2'd1;
        tick();
        chk_state("t4_legal", 2'd1, 3'b010);
        in_idx = 2'd3;
        tick();
        chk_state("t4_oor_lvl1", 2'd1, 3'b010);

        // T1: async reset while full
        in_idx = 2'd0;
        tick();
        chk_state("t1_full", 2'd2, 3'b010);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_state("t1_async", 2'd0, 3'b000);
        check("t1_err", 32'(err_oor), 32'd0);
        rst = 1'b0;
        tick();
        chk_state("t1_after", 2'd0, 3'b000);

`ifdef LINE_HIST_EN
        // T6: history of popped lines and clear with concurrent pop
        check("t6_reset", 32'(hist_mask), 32'd0);
        in_valid = 1'b1;
        in_idx   = 2'd0;
        tick();
        in_idx = 2'd2;
        tick();
        check("t6_nopop", 32'(hist_mask), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_pop1", 32'(hist_mask), 32'b001);
        tick();
        check("t6_pop2", 32'(hist_mask), 32'b101);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 2'd1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hist_clr  = 1'b1;
        tick();
        check("t6_clr_pop", 32'(hist_mask), 32'b010);
        hist_clr = 1'b0;
        tick();
        check("t6_hold", 32'(hist_mask), 32'b010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
